// File: rtl/hemaia_mem_sys_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hemaia_mem_sys_pkg : shared types and defaults for the HeMAiA memory system |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package hemaia_mem_sys_pkg;

  typedef enum logic [1:0] {
    SB_IDLE   = 2'd0,
    SB_WIDE   = 2'd1,
    SB_NARROW = 2'd2
  } sb_state_e;

  localparam int unsigned SB_NUM_NARROW_DEFAULT       = 8;
  localparam int unsigned SB_MAX_WIDE_BURST_DEFAULT   = 4;
  localparam int unsigned SB_MAX_NARROW_BURST_DEFAULT = 2;

  function automatic int unsigned sb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hemaia_mem_sb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hemaia_mem_sb_arbiter : wide/narrow superbank arbiter with burst fairness    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module hemaia_mem_sb_arbiter
  import hemaia_mem_sys_pkg::*;
#(
  parameter int unsigned NumNarrow      = SB_NUM_NARROW_DEFAULT,
  parameter int unsigned MaxWideBurst   = SB_MAX_WIDE_BURST_DEFAULT,
  parameter int unsigned MaxNarrowBurst = SB_MAX_NARROW_BURST_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 wide_valid_i,
  input  logic [NumNarrow-1:0] narrow_valid_i,
  output logic                 sel_wide_o,
  output logic                 wide_gnt_o,
  output logic [NumNarrow-1:0] narrow_gnt_o,
  output logic                 resp_wide_o,
  output logic [NumNarrow-1:0] resp_narrow_o
);

  localparam int unsigned           CNT_W      = $clog2(sb_max(MaxWideBurst, MaxNarrowBurst) + 1);
  localparam logic [CNT_W-1:0]      WIDE_LIM   = CNT_W'(MaxWideBurst);
  localparam logic [CNT_W-1:0]      NARROW_LIM = CNT_W'(MaxNarrowBurst);

  sb_state_e        r_state;
  sb_state_e        w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  logic w_wide_pend;
  logic w_narrow_pend;
  logic w_force_narrow;
  logic w_narrow_any_gnt;

  assign w_wide_pend      = wide_valid_i;
  assign w_narrow_pend    = |narrow_valid_i;
  assign w_narrow_any_gnt = |narrow_gnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= SB_IDLE;
      r_cnt         <= '0;
      resp_wide_o   <= 1'b0;
      resp_narrow_o <= '0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      resp_wide_o   <= wide_gnt_o;
      resp_narrow_o <= narrow_gnt_o;
    end
  end

  // The counter saturates at the owning side's burst limit so that a lone
  // requester keeps the superbank but still yields the moment the other side asks.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (wide_gnt_o) begin
      if (r_state == SB_WIDE) begin
        if (r_cnt != WIDE_LIM) w_cnt_d = r_cnt + CNT_W'(1);
      end else begin
        w_state_d = SB_WIDE;
        w_cnt_d   = CNT_W'(1);
      end
    end else if (w_narrow_any_gnt) begin
      if (r_state == SB_NARROW) begin
        if (r_cnt != NARROW_LIM) w_cnt_d = r_cnt + CNT_W'(1);
      end else begin
        w_state_d = SB_NARROW;
        w_cnt_d   = CNT_W'(1);
      end
    end else begin
      w_state_d = SB_IDLE;
      w_cnt_d   = '0;
    end
  end

  always_comb begin
    w_force_narrow = w_narrow_pend &&
                     (((r_state == SB_WIDE)   && (r_cnt == WIDE_LIM)) ||
                      ((r_state == SB_NARROW) && (r_cnt <  NARROW_LIM)));
    sel_wide_o     = en_i && w_wide_pend && !w_force_narrow;
    wide_gnt_o     = sel_wide_o;
    narrow_gnt_o   = (en_i && !sel_wide_o) ? narrow_valid_i : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_hemaia_mem_sb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hemaia_mem_sb_arbiter : scoreboard bench for the superbank arbiter        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_hemaia_mem_sb_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic       wide_valid_i = 1'b1;
  logic [7:0] narrow_valid_i = 8'hFF;
  logic       sel_wide_o;
  logic       wide_gnt_o;
  logic [7:0] narrow_gnt_o;
  logic       resp_wide_o;
  logic [7:0] resp_narrow_o;

  hemaia_mem_sb_arbiter #(
    .NumNarrow      (8),
    .MaxWideBurst   (4),
    .MaxNarrowBurst (2)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .wide_valid_i   (wide_valid_i),
    .narrow_valid_i (narrow_valid_i),
    .sel_wide_o     (sel_wide_o),
    .wide_gnt_o     (wide_gnt_o),
    .narrow_gnt_o   (narrow_gnt_o),
    .resp_wide_o    (resp_wide_o),
    .resp_narrow_o  (resp_narrow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [18:0] exp;
    string       name;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [18:0] mon_act;
  int         n_pass  = 0;
  int         n_total = 0;
  logic       prev_w  = 1'b0;
  logic [7:0] prev_n  = 8'h00;

  // One stimulus cycle: expected grant is hand-written, expected response is
  // the previous cycle's expected grant.
  task automatic cyc(input logic en, input logic wv, input logic [7:0] nv,
                     input logic exp_w, input logic [7:0] exp_n, input string name);
    exp_t e;
    en_i           = en;
    wide_valid_i   = wv;
    narrow_valid_i = nv;
    e.exp  = {exp_w, exp_w, exp_n, prev_w, prev_n};
    e.name = name;
    sb_q.push_back(e);
    prev_w = exp_w;
    prev_n = exp_n;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        mon_e   = sb_q.pop_front();
        mon_act = {sel_wide_o, wide_gnt_o, narrow_gnt_o, resp_wide_o, resp_narrow_o};
        n_total++;
        if (mon_act === mon_e.exp) n_pass++;
        else $display("FAIL %s: got {sel,wg,ng,rw,rn}=%h expected %h",
                      mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic W = 1'b1;
  localparam logic N = 1'b0;

  initial begin
    // Reset held under full load
    #3;
    chk("reset_resp", {resp_wide_o, resp_narrow_o}, 9'h000);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Contention: W,W,W,W,N,N repeating; first cycle after release is wide
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 8'hFF, W, 8'h00, "contend_w");
      for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 8'hFF, N, 8'hFF, "contend_n");
    end

    // Asynchronous reset mid-operation drops the pending narrow response
    chk("pre_reset_resp", {resp_wide_o, resp_narrow_o}, 9'h0FF);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_reset_resp", {resp_wide_o, resp_narrow_o}, 9'h000);
    @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    prev_w = 1'b0;
    prev_n = 8'h00;

    // Wide only: lone requester, counter saturates
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 8'h00, W, 8'h00, "wide_only");
    // Narrow arrives after a long wide run: saturated counter forces narrow at once
    cyc(1'b1, 1'b1, 8'hFF, N, 8'hFF, "sat_switch_n0");
    cyc(1'b1, 1'b1, 8'hFF, N, 8'hFF, "sat_switch_n1");
    cyc(1'b1, 1'b1, 8'hFF, W, 8'h00, "sat_switch_w");

    // Narrow only
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'h05, N, 8'h05, "narrow_only");

    // Mid-burst wide arrival: one more narrow, then wide
    cyc(1'b1, 1'b0, 8'h00, N, 8'h00, "idle_gap");
    cyc(1'b1, 1'b0, 8'h0F, N, 8'h0F, "midburst_n1");
    cyc(1'b1, 1'b1, 8'h0F, N, 8'h0F, "midburst_n2");
    cyc(1'b1, 1'b1, 8'h0F, W, 8'h00, "midburst_w");
    cyc(1'b1, 1'b1, 8'h0F, W, 8'h00, "midburst_w2");

    // Enable gating under full load, then wide first from IDLE
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'hFF, N, 8'h00, "disabled");
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 8'hFF, W, 8'h00, "reen_w");
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 8'hFF, N, 8'hFF, "reen_n");

    @(negedge clk_i);
    #1;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hemaia_mem_sb_arbiter.md
HEMAIA_MEM_SB_ARBITER -- requirements
Module: hemaia_mem_sb_arbiter

Interface
REQ-001 SHALL have parameter NumNarrow, default 8, meaning narrow bank ports per superbank (AXI wide data width / 64).
REQ-002 SHALL have parameter MaxWideBurst, default 4, meaning max consecutive wide grants while narrow pending; legal range 1..255.
REQ-003 SHALL have parameter MaxNarrowBurst, default 2, meaning max consecutive narrow grants while wide pending; legal range 1..255.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit, arbitration enable.
REQ-007 SHALL have port wide_valid_i, input, 1 bit, wide (AXI-to-mem) superbank request valid.
REQ-008 SHALL have port narrow_valid_i, input, NumNarrow bits, per-bank XDMA request valid.
REQ-009 SHALL have port sel_wide_o, output, 1 bit, mux select: wide side owns the superbank this cycle.
REQ-010 SHALL have port wide_gnt_o, output, 1 bit, wide request accepted this cycle.
REQ-011 SHALL have port narrow_gnt_o, output, NumNarrow bits, per-bank narrow requests accepted this cycle.
REQ-012 SHALL have port resp_wide_o, output, 1 bit, route read response (p_valid) to wide side this cycle.
REQ-013 SHALL have port resp_narrow_o, output, NumNarrow bits, per-bank narrow response valid this cycle.

Function
REQ-014 SHALL define wide_pend = wide_valid_i and narrow_pend = OR of narrow_valid_i.
REQ-015 SHALL hold FSM states IDLE (no grant last cycle), WIDE, NARROW, plus one burst counter cnt of width clog2(max(MaxWideBurst,MaxNarrowBurst)+1).
REQ-016 SHALL compute grants combinationally from current inputs and state, giving zero-cycle grant latency.
REQ-017 SHALL, with en_i low, drive sel_wide_o, wide_gnt_o and narrow_gnt_o to 0.
REQ-018 SHALL, with en_i high, force narrow iff narrow_pend and ((state==WIDE and cnt==MaxWideBurst) or (state==NARROW and cnt<MaxNarrowBurst)).
REQ-019 SHALL set sel_wide_o = en_i and wide_pend and not force narrow; in IDLE with both pending, wide wins.
REQ-020 SHALL set wide_gnt_o = sel_wide_o, and narrow_gnt_o = narrow_valid_i when en_i high and not sel_wide_o, else 0.
REQ-021 SHALL update on each edge: on a grant to side X with state==X, cnt increments saturating at its max; on a grant to X with state!=X, state<=X and cnt<=1; with no grant, state<=IDLE and cnt<=0.
REQ-022 SHALL treat a lone requester as unlimited: the counter saturates and no switch occurs while the other side is idle.
REQ-023 SHALL register resp_wide_o<=wide_gnt_o and resp_narrow_o<=narrow_gnt_o, giving 1-cycle response latency to match the SRAM banks.
REQ-024 SHALL, with MaxWideBurst=MaxNarrowBurst=1 and both sides pending, alternate W,N,W,N each cycle.
REQ-025 SHALL, on deassertion of en_i, go to IDLE with cnt=0 on the next edge; resp outputs still reflect the previous cycle's grants.

Reset
REQ-026 SHALL, while rst_i is high, immediately force state=IDLE, cnt=0 and resp_wide_o=resp_narrow_o=0, independent of clk_i.
REQ-027 SHALL, on reset mid-operation, drop in-flight responses (not replay them); the requesters retry.

Structure
REQ-028 SHALL take the FSM state enum and the default burst constants from the shared package hemaia_mem_sys_pkg.
REQ-029 SHALL need no sub-module; the memory system instantiates one instance per superbank in its generate loop, driving the wide/narrow mux select and the q_ready gating.

Verification
REQ-030 SHALL cover reset: rst_i=1 with wide_valid_i=1, narrow_valid_i=0xFF, en_i=1 -> resp_wide_o=0 and resp_narrow_o=0x00 asynchronously; first cycle after release grants wide.
REQ-031 SHALL cover wide-only: 10 cycles wide_valid_i=1, narrow_valid_i=0 -> wide_gnt_o=1 all 10 cycles; resp_wide_o=1 from cycle 2 to 11.
REQ-032 SHALL cover contention: NumNarrow=8, MaxWideBurst=4, MaxNarrowBurst=2, wide_valid_i=1, narrow_valid_i=0xFF constant -> grant pattern W,W,W,W,N,N repeating; narrow_gnt_o=0xFF on N cycles.
REQ-033 SHALL cover narrow-only: narrow_valid_i=0x05, wide 0 -> narrow_gnt_o=0x05 same cycle and resp_narrow_o=0x05 next cycle.
REQ-034 SHALL cover mid-burst arrival: narrow granted 1 cycle (cnt=1), then wide_valid_i rises -> one more narrow grant, then wide.
REQ-035 SHALL cover enable gating: en_i=0 for 3 cycles under full load -> no grants; on re-enable wide is granted first (from IDLE).
